// File: rtl/des_pkg.sv
// Shared DES constants, state encoding and round-function tables (E, P, S1-S8).
// Bit numbering follows the DES standard: index 1 is the most significant bit.
package des_pkg;

    localparam int DES_ROUNDS = 16;
    localparam int KEY_W      = 48;
    localparam int BLOCK_W    = 64;
    localparam int HALF_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } dec_state_e;

    localparam int E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box is stored row-major: entry = row*16 + column.
    localparam int S_BOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [1:KEY_W] e_expand(input logic [1:HALF_W] r);
        logic [1:KEY_W] e;
        e = '0;
        for (int i = 0; i < KEY_W; i++) e[i+1] = r[E_TABLE[i]];
        return e;
    endfunction

    function automatic logic [1:HALF_W] p_permute(input logic [1:HALF_W] x);
        logic [1:HALF_W] p;
        p = '0;
        for (int i = 0; i < HALF_W; i++) p[i+1] = x[P_TABLE[i]];
        return p;
    endfunction

    // Outer bits of each 6-bit group pick the row, inner four bits the column.
    function automatic logic [1:HALF_W] s_substitute(input logic [1:KEY_W] x);
        logic [1:HALF_W] s;
        logic [5:0]      six;
        logic [5:0]      idx;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[6*b+1 +: 6];
            idx = {six[5], six[0], six[4:1]};
            s[4*b+1 +: 4] = 4'(S_BOX[b][idx]);
        end
        return s;
    endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R, K) = P(S(E(R) xor K)); combinational, shared with the encrypt round.
module des_f_function
    import des_pkg::*;
(
    input  logic [1:HALF_W] r,
    input  logic [1:KEY_W]  k,
    output logic [1:HALF_W] f
);

    always_comb begin
        f = p_permute(s_substitute(e_expand(r) ^ k));
    end

endmodule

// File: rtl/ip_inverse_permutation.sv
// DES final permutation (IP inverse), pure wiring.
module ip_inverse_permutation (
    input  logic [1:64] data_in,
    output logic [1:64] data_out
);

    localparam int FP_TABLE [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };

    always_comb begin
        data_out = '0;
        for (int i = 0; i < 64; i++) data_out[i+1] = data_in[FP_TABLE[i]];
    end

endmodule

// File: rtl/ip_permutation.sv
// DES initial permutation (IP), pure wiring.
module ip_permutation (
    input  logic [1:64] data_in,
    output logic [1:64] data_out
);

    localparam int IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
    };

    always_comb begin
        data_out = '0;
        for (int i = 0; i < 64; i++) data_out[i+1] = data_in[IP_TABLE[i]];
    end

endmodule

// File: rtl/des_decryption_iterative.sv
// Iterative DES decryption: one Feistel round per clock, keys applied K16 down to K1.
// A block occupies the core for 18 cycles from accept to the next possible accept.
module des_decryption_iterative
    import des_pkg::*;
#(
    parameter int ROUNDS = DES_ROUNDS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          ready,
    input  logic [1:BLOCK_W]              ciphertext,
    input  logic [1:KEY_W*DES_ROUNDS]     round_keys,
    output logic                          output_valid,
    output logic [1:BLOCK_W]              result
);

    dec_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:HALF_W]  l_q, l_d;
    logic [1:HALF_W]  r_q, r_d;
    logic [1:BLOCK_W] result_q, result_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;

    logic [1:BLOCK_W] ip_out;
    logic [1:BLOCK_W] ip_inv_out;
    logic [1:KEY_W]   key_arr [DES_ROUNDS];
    logic [3:0]       key_idx;
    logic [1:KEY_W]   round_key;
    logic [1:HALF_W]  f_out;

    ip_permutation u_ip (
        .data_in  (ciphertext),
        .data_out (ip_out)
    );

    // Halves go out swapped, undoing the swap of the last Feistel round.
    ip_inverse_permutation u_ip_inv (
        .data_in  ({r_q, l_q}),
        .data_out (ip_inv_out)
    );

    des_f_function u_f (
        .r (r_q),
        .k (round_key),
        .f (f_out)
    );

    always_comb begin
        for (int n = 0; n < DES_ROUNDS; n++) key_arr[n] = round_keys[KEY_W*n+1 +: KEY_W];
        key_idx   = 4'(DES_ROUNDS - 1) - cnt_q;
        round_key = key_arr[key_idx];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        l_d      = l_q;
        r_d      = r_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    {l_d, r_d} = ip_out;
                    cnt_d      = '0;
                    state_d    = ROUND;
                end
            end
            ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ f_out;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(ROUNDS - 1)) state_d = DONE;
            end
            DONE: begin
                result_d = ip_inv_out;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            l_q      <= '0;
            r_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            l_q      <= l_d;
            r_q      <= r_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign ready        = ready_q;
    assign output_valid = valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_des_decryption_iterative.sv
// Scoreboard bench for des_decryption_iterative: a forward DES model encrypts random
// plaintexts, the DUT must return them; a negedge monitor checks value and latency.
module tb_des_decryption_iterative;

    localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,
                                  19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                  41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int S_T [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    logic         clk;
    logic         rst;
    logic         start;
    logic         ready;
    logic [63:0]  ciphertext;
    logic [767:0] round_keys;
    logic         output_valid;
    logic [63:0]  result;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           ready_at = 0;
    logic [63:0]  exp_q [$];
    int           stamp_q [$];
    logic [63:0]  last_result = '0;
    logic         prev_valid  = 1'b0;

    des_decryption_iterative dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ready        (ready),
        .ciphertext   (ciphertext),
        .round_keys   (round_keys),
        .output_valid (output_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: textbook forward DES, bit n (1 = MSB) of a W-bit word sits at index W-n.
    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, p;
        logic [5:0]  six;
        int          row, col;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six = e[47-6*b -: 6];
            row = 2*int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s[31-4*b -: 4] = 4'(S_T[b][row*16 + col]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    function automatic logic [767:0] key_schedule(input logic [63:0] key);
        logic [55:0]  cd;
        logic [27:0]  c, d;
        logic [47:0]  k;
        logic [767:0] rk;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SHIFT_T[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
            rk[767-48*n -: 48] = k;
        end
        return rk;
    endfunction

    function automatic logic [63:0] encrypt_model(input logic [63:0] pt, input logic [767:0] rk);
        logic [63:0] x, pre, out;
        logic [31:0] l, r, t;
        for (int i = 0; i < 64; i++) x[63-i] = pt[64-IP_T[i]];
        l = x[63:32];
        r = x[31:0];
        for (int n = 0; n < 16; n++) begin
            t = r;
            r = l ^ f_model(r, rk[767-48*n -: 48]);
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) out[64-IP_T[i]] = pre[63-i];
        return out;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One negedge of stimulus; acceptance is decided by the bench's own idea of when the core is idle.
    task automatic apply_stimulus(input logic [63:0] ct, input logic [767:0] keys,
                                  input logic [63:0] pt, input logic do_start, output logic accepted);
        logic ready_exp;
        @(negedge clk);
        start      = do_start;
        ciphertext = ct;
        round_keys = keys;
        ready_exp  = (cyc >= ready_at);
        check_eq("ready", 64'(ready), 64'(ready_exp));
        accepted = do_start && ready_exp;
        if (accepted) begin
            exp_q.push_back(pt);
            stamp_q.push_back(cyc + 1);
            ready_at = cyc + 18;
        end
    endtask

    task automatic wait_idle(input logic [767:0] keys);
        logic acc;
        int   waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 60) begin
            apply_stimulus(ciphertext, keys, 64'd0, 1'b0, acc);
            waited++;
        end
        if (exp_q.size() != 0) check_eq("completion_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_block(input logic [63:0] ct, input logic [767:0] keys, input logic [63:0] pt);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 40) begin
            apply_stimulus(ct, keys, pt, 1'b1, acc);
            tries++;
        end
        if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
        apply_stimulus(ct, keys, pt, 1'b0, acc);
        wait_idle(keys);
    endtask

    task automatic check_output();
        logic [63:0] exp;
        int          st;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL spurious_valid: got result %h with no block in flight, expected no valid", result);
        end else begin
            exp = exp_q.pop_front();
            st  = stamp_q.pop_front();
            check_eq("result", result, exp);
            check_eq("latency", 64'(cyc - st), 64'd17);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_result = '0;
            prev_valid  = 1'b0;
        end else begin
            if (output_valid) begin
                check_eq("valid_width", 64'(prev_valid), 64'd0);
                check_output();
                last_result = result;
            end else begin
                check_eq("result_hold", result, last_result);
            end
            prev_valid = output_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [767:0] keys;
        logic [767:0] std_keys;
        logic [63:0]  pt, ct;
        logic         acc;
        int           accepts;

        rst        = 1'b1;
        start      = 1'b0;
        ciphertext = '0;
        round_keys = '0;
        #7;
        check_eq("reset_ready", 64'(ready), 64'd1);
        check_eq("reset_valid", 64'(output_valid), 64'd0);
        check_eq("reset_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] known answer, standard key");
        std_keys = key_schedule(64'h133457799BBCDFF1);
        run_block(64'h85E813540F0AB405, std_keys, 64'h0123456789ABCDEF);

        $display("[TB] known answer, all-zero key");
        run_block(64'h8CA64DE9C1B123A7, key_schedule(64'd0), 64'd0);

        $display("[TB] loopback, 100 random blocks");
        for (int i = 0; i < 100; i++) begin
            if (i % 4 == 3) begin
                for (int w = 0; w < 24; w++) keys[32*w +: 32] = $urandom();
            end else begin
                keys = key_schedule({$urandom(), $urandom()});
            end
            pt = {$urandom(), $urandom()};
            run_block(encrypt_model(pt, keys), keys, pt);
        end

        $display("[TB] start held high with changing ciphertext");
        keys    = key_schedule({$urandom(), $urandom()});
        accepts = 0;
        for (int i = 0; i < 60; i++) begin
            pt = {$urandom(), $urandom()};
            ct = encrypt_model(pt, keys);
            apply_stimulus(ct, keys, pt, 1'b1, acc);
            if (acc) accepts++;
        end
        apply_stimulus(64'd0, keys, 64'd0, 1'b0, acc);
        wait_idle(keys);
        check_eq("busy_accepts", 64'(accepts), 64'd4);

        $display("[TB] reset during round 7");
        pt = 64'h0123456789ABCDEF;
        while (!(cyc >= ready_at)) apply_stimulus(ciphertext, std_keys, pt, 1'b0, acc);
        apply_stimulus(64'h85E813540F0AB405, std_keys, pt, 1'b1, acc);
        check_eq("abort_accept", 64'(acc), 64'd1);
        for (int i = 0; i < 7; i++) apply_stimulus(64'h85E813540F0AB405, std_keys, pt, 1'b0, acc);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        stamp_q.delete();
        ready_at = 0;
        check_eq("abort_ready", 64'(ready), 64'd1);
        check_eq("abort_valid", 64'(output_valid), 64'd0);
        check_eq("abort_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_block(64'h85E813540F0AB405, std_keys, 64'h0123456789ABCDEF);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
